// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - fetches PIX_PER_WIN pixels per window, hands them to compute, writes the result back
// Moore FSM. Strobes are decoded from the state register so an async reset drops them at once.
module window_sequencer #(
  parameter int PIX_PER_WIN = 16,
  parameter int TOTAL_WIN   = 20164
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_start,
  input  logic         i_abort,
  output logic         o_inc_raddr,
  input  logic         i_raddr_ready,
  output logic         o_inc_waddr,
  input  logic         i_waddr_ready,
  output logic         o_mem_read,
  output logic         o_mem_write,
  input  logic         i_mem_ack,
  input  logic [7:0]   i_rdata,
  output logic [7:0]   o_wdata,
  output logic [127:0] o_window,
  output logic         o_window_valid,
  input  logic         i_calc_done,
  input  logic [7:0]   i_result,
  output logic         o_busy,
  output logic         o_done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] REQ_R   = 4'd1;
  localparam logic [3:0] WAIT_R  = 4'd2;
  localparam logic [3:0] READ    = 4'd3;
  localparam logic [3:0] COMPUTE = 4'd4;
  localparam logic [3:0] REQ_W   = 4'd5;
  localparam logic [3:0] WAIT_W  = 4'd6;
  localparam logic [3:0] WRITE   = 4'd7;
  localparam logic [3:0] DONE    = 4'd8;

  localparam logic [3:0]  PIX_LAST = 4'(PIX_PER_WIN - 1);
  localparam logic [15:0] WIN_LAST = 16'(TOTAL_WIN - 1);

  logic [3:0]   state_q,   state_d;
  logic [3:0]   pix_cnt_q, pix_cnt_d;
  logic [15:0]  win_cnt_q, win_cnt_d;
  logic [127:0] window_q,  window_d;
  logic [7:0]   wdata_q,   wdata_d;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    win_cnt_d = win_cnt_q;
    window_d  = window_q;
    wdata_d   = wdata_q;
    if (i_abort) begin
      state_d   = IDLE;
      pix_cnt_d = 4'd0;
      win_cnt_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) state_d = REQ_R;
        end
        REQ_R: begin
          state_d = WAIT_R;
        end
        WAIT_R: begin
          if (i_raddr_ready) state_d = READ;
        end
        READ: begin
          if (i_mem_ack) begin
            window_d[{pix_cnt_q, 3'b000} +: 8] = i_rdata;
            pix_cnt_d = pix_cnt_q + 4'd1;
            state_d   = (pix_cnt_q == PIX_LAST) ? COMPUTE : REQ_R;
          end
        end
        COMPUTE: begin
          if (i_calc_done) begin
            wdata_d   = i_result;
            pix_cnt_d = 4'd0;
            state_d   = REQ_W;
          end
        end
        REQ_W: begin
          state_d = WAIT_W;
        end
        WAIT_W: begin
          if (i_waddr_ready) state_d = WRITE;
        end
        WRITE: begin
          if (i_mem_ack) begin
            win_cnt_d = win_cnt_q + 16'd1;
            state_d   = (win_cnt_q == WIN_LAST) ? DONE : REQ_R;
          end
        end
        DONE: begin
          win_cnt_d = 16'd0;
          state_d   = IDLE;
        end
        default: begin
          state_d   = IDLE;
          pix_cnt_d = 4'd0;
          win_cnt_d = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= 4'd0;
      win_cnt_q <= 16'd0;
      window_q  <= 128'd0;
      wdata_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      win_cnt_q <= win_cnt_d;
      window_q  <= window_d;
      wdata_q   <= wdata_d;
    end
  end

  assign o_inc_raddr    = (state_q == REQ_R);
  assign o_mem_read     = (state_q == READ);
  assign o_window_valid = (state_q == COMPUTE);
  assign o_inc_waddr    = (state_q == REQ_W);
  assign o_mem_write    = (state_q == WRITE);
  assign o_done         = (state_q == DONE);
  assign o_busy         = (state_q != IDLE);
  assign o_window       = window_q;
  assign o_wdata        = wdata_q;

endmodule

// File: tb/tb_window_sequencer.sv
// tb/tb_window_sequencer.sv - directed bench for window_sequencer
// u_one runs a single-window frame, u_three a three-window frame; sel picks whose outputs are observed.
module tb_window_sequencer;

  logic clk = 1'b0;
  logic n_rst, start, abort, raddr_ready, waddr_ready, mem_ack, calc_done;
  logic [7:0] rdata, result;
  logic sel;

  logic         a_inc_raddr, a_inc_waddr, a_mem_read, a_mem_write, a_valid, a_busy, a_done;
  logic [7:0]   a_wdata;
  logic [127:0] a_window;
  logic         b_inc_raddr, b_inc_waddr, b_mem_read, b_mem_write, b_valid, b_busy, b_done;
  logic [7:0]   b_wdata;
  logic [127:0] b_window;

  logic         m_inc_raddr, m_inc_waddr, m_mem_read, m_mem_write, m_valid, m_busy, m_done;
  logic [7:0]   m_wdata;
  logic [127:0] m_window;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rinc = 0, n_winc = 0, n_rd = 0;
  logic [127:0] exp_win;
  int exp_pix;

  always #5 clk = ~clk;

  window_sequencer #(.PIX_PER_WIN(4), .TOTAL_WIN(1)) u_one (
    .clk(clk), .n_rst(n_rst), .i_start(start), .i_abort(abort),
    .o_inc_raddr(a_inc_raddr), .i_raddr_ready(raddr_ready),
    .o_inc_waddr(a_inc_waddr), .i_waddr_ready(waddr_ready),
    .o_mem_read(a_mem_read), .o_mem_write(a_mem_write), .i_mem_ack(mem_ack),
    .i_rdata(rdata), .o_wdata(a_wdata), .o_window(a_window), .o_window_valid(a_valid),
    .i_calc_done(calc_done), .i_result(result), .o_busy(a_busy), .o_done(a_done)
  );

  window_sequencer #(.PIX_PER_WIN(4), .TOTAL_WIN(3)) u_three (
    .clk(clk), .n_rst(n_rst), .i_start(start), .i_abort(abort),
    .o_inc_raddr(b_inc_raddr), .i_raddr_ready(raddr_ready),
    .o_inc_waddr(b_inc_waddr), .i_waddr_ready(waddr_ready),
    .o_mem_read(b_mem_read), .o_mem_write(b_mem_write), .i_mem_ack(mem_ack),
    .i_rdata(rdata), .o_wdata(b_wdata), .o_window(b_window), .o_window_valid(b_valid),
    .i_calc_done(calc_done), .i_result(result), .o_busy(b_busy), .o_done(b_done)
  );

  assign m_inc_raddr = sel ? b_inc_raddr : a_inc_raddr;
  assign m_inc_waddr = sel ? b_inc_waddr : a_inc_waddr;
  assign m_mem_read  = sel ? b_mem_read  : a_mem_read;
  assign m_mem_write = sel ? b_mem_write : a_mem_write;
  assign m_valid     = sel ? b_valid     : a_valid;
  assign m_busy      = sel ? b_busy      : a_busy;
  assign m_done      = sel ? b_done      : a_done;
  assign m_wdata     = sel ? b_wdata     : a_wdata;
  assign m_window    = sel ? b_window    : a_window;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every cycle advance goes through here so strobe cycles are counted exactly once.
  task automatic step();
    if (m_inc_raddr) n_rinc++;
    if (m_inc_waddr) n_winc++;
    if (m_mem_read)  n_rd++;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] d, input int nwait, input bit spur);
    chk("r_req", 128'(m_inc_raddr), 128'(1));
    step();
    chk("r_wait", 128'({m_inc_raddr, m_mem_read}), 128'(0));
    if (spur) begin
      calc_done = 1'b1; mem_ack = 1'b1; rdata = 8'hEE;
      step();
      calc_done = 1'b0; mem_ack = 1'b0;
      chk("spur_state", 128'({m_mem_read, m_valid, m_inc_raddr, m_busy}), 128'(4'b0001));
      chk("spur_win", m_window, exp_win);
    end
    raddr_ready = 1'b1;
    step();
    raddr_ready = 1'b0;
    chk("r_read", 128'(m_mem_read), 128'(1));
    for (int i = 0; i < nwait; i++) begin
      rdata = ~d;
      step();
      chk("r_hold", 128'(m_mem_read), 128'(1));
    end
    chk("r_nocap", m_window, exp_win);
    rdata = d; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    exp_win[exp_pix*8 +: 8] = d;
    exp_pix++;
    chk("r_cap", m_window, exp_win);
  endtask

  task automatic do_pixels(input logic [7:0] base, input logic [7:0] inc, input int nwait, input bit spur);
    for (int k = 0; k < 4; k++)
      do_read(base + 8'(k) * inc, (k == 1) ? nwait : 0, (k == 2) ? spur : 1'b0);
    chk("compute", 128'({m_valid, m_mem_read, m_inc_raddr}), 128'(3'b100));
  endtask

  task automatic do_window(input logic [7:0] base, input logic [7:0] inc, input logic [7:0] res,
                           input int nwait, input bit spur);
    do_pixels(base, inc, nwait, spur);
    result = res; calc_done = 1'b1;
    step();
    calc_done = 1'b0; result = 8'h00;
    exp_pix = 0;
    chk("w_req", 128'({m_inc_waddr, m_valid}), 128'(2'b10));
    chk("w_data_latch", 128'(m_wdata), 128'(res));
    step();
    chk("w_wait", 128'({m_inc_waddr, m_mem_write}), 128'(0));
    waddr_ready = 1'b1;
    step();
    waddr_ready = 1'b0;
    chk("w_write", 128'(m_mem_write), 128'(1));
    chk("w_data", 128'(m_wdata), 128'(res));
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    step(); step();
    exp_win = 128'd0; exp_pix = 0;
    n_rst = 1'b1;
    step();
  endtask

  initial begin
    int b_rinc, b_winc, b_rd;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; raddr_ready = 1'b0; waddr_ready = 1'b0;
    mem_ack = 1'b0; calc_done = 1'b0; rdata = 8'h00; result = 8'h00; sel = 1'b0;
    exp_win = 128'd0; exp_pix = 0;
    @(negedge clk);
    step();
    chk("rst_strobes", 128'({a_inc_raddr, a_inc_waddr, a_mem_read, a_mem_write, a_valid, a_busy, a_done}), 128'(0));
    chk("rst_window", a_window, 128'd0);
    chk("rst_wdata", 128'(a_wdata), 128'(0));
    n_rst = 1'b1;
    step();

    // single window, delayed ack on pixel 1, spurious pulses on pixel 2
    b_rinc = n_rinc; b_winc = n_winc; b_rd = n_rd;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 128'(m_busy), 128'(1));
    do_window(8'h11, 8'h11, 8'hAB, 5, 1'b1);
    chk("one_window", m_window[31:0], 128'(32'h44332211));
    chk("one_rinc", 128'(n_rinc - b_rinc), 128'(4));
    chk("one_winc", 128'(n_winc - b_winc), 128'(1));
    chk("one_rd_cycles", 128'(n_rd - b_rd), 128'(9));
    chk("one_done", 128'({m_done, m_busy}), 128'(2'b11));
    step();
    chk("one_idle", 128'({m_done, m_busy}), 128'(0));

    // three-window frame; start held high through window 0 must be ignored
    sel = 1'b1;
    do_reset();
    b_winc = n_winc;
    start = 1'b1;
    step();
    for (int w = 0; w < 3; w++) begin
      do_window(8'h10 * 8'(w + 1), 8'h01, 8'hC0 + 8'(w), 0, 1'b0);
      start = 1'b0;
      if (w < 2) chk("next_win", 128'({m_inc_raddr, m_done}), 128'(2'b10));
    end
    chk("frame_winc", 128'(n_winc - b_winc), 128'(3));
    chk("frame_done", 128'(m_done), 128'(1));
    step();
    chk("frame_idle", 128'({m_done, m_busy}), 128'(0));

    // abort in COMPUTE, then restart fills slot 0 and leaves stale slots
    start = 1'b1;
    step();
    start = 1'b0;
    do_pixels(8'hA0, 8'h01, 0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_pix = 0;
    chk("abort_idle", 128'({m_valid, m_busy}), 128'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    do_read(8'h5A, 0, 1'b0);
    chk("restart_slot", m_window[31:0], 128'(32'hA3A2A15A));

    // reset asserted while the read strobe is held
    step();
    raddr_ready = 1'b1;
    step();
    raddr_ready = 1'b0;
    chk("pre_rst_read", 128'(m_mem_read), 128'(1));
    #1 n_rst = 1'b0;
    #1;
    chk("rst_drop", 128'({m_mem_read, m_busy}), 128'(0));
    chk("rst_window_clr", m_window, 128'd0);
    step();
    n_rst = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
